// File: rtl/ra_stack_writer_pkg.sv
// Shared XM-stage decode definitions: opcode constants, link-register default,
// and the event decode used by the link-register writer and its return-address stack.
package ra_stack_writer_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;

    localparam logic [4:0] LINK_REG_DEFAULT = 5'd31;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_PUSH,
        EV_OVERWRITE,
        EV_POP
    } ras_event_e;

    typedef enum logic [1:0] {
        SRC_ALU,
        SRC_LOAD,
        SRC_PC
    } wr_src_e;

    typedef struct packed {
        ras_event_e ev;
        wr_src_e    src;
    } xm_decode_t;

    // One instruction per cycle, so the events are mutually exclusive by construction.
    function automatic xm_decode_t decode_xm(input logic [31:0] instr,
                                             input logic [4:0]  link_reg);
        xm_decode_t dec;
        logic [4:0] op;
        logic [4:0] rd;
        op      = instr[31:27];
        rd      = instr[26:22];
        dec.ev  = EV_NONE;
        dec.src = SRC_ALU;
        case (op)
            OP_JAL: begin
                dec.ev  = EV_PUSH;
                dec.src = SRC_PC;
            end
            OP_LW: begin
                dec.src = SRC_LOAD;
                if (rd == link_reg) dec.ev = EV_OVERWRITE;
            end
            OP_RTYPE, OP_ADDI: begin
                if (rd == link_reg) dec.ev = EV_OVERWRITE;
            end
            OP_JR: begin
                if (rd == link_reg) dec.ev = EV_POP;
            end
            default: ;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/ra_stack_writer_if.sv
// XM-stage bundle between the pipeline (master) and the link-register writer (slave):
// instruction/operand inputs, the register-file write port and the RAS status outputs.
interface ra_stack_writer_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);

    logic                     stall;
    logic [31:0]              xm_instruction;
    logic [WIDTH-1:0]         xm_pc_plus_1;
    logic [WIDTH-1:0]         next_mw_d;
    logic [WIDTH-1:0]         next_mw_o;

    logic                     ra_wr_en;
    logic [WIDTH-1:0]         ra_wr_data;
    logic [WIDTH-1:0]         ra_arch;
    logic [WIDTH-1:0]         ras_top;
    logic                     ras_empty;
    logic [$clog2(DEPTH):0]   ras_count;
    logic                     ras_overflow;
    logic                     ras_underflow;

    modport master (
        output stall, xm_instruction, xm_pc_plus_1, next_mw_d, next_mw_o,
        input  ra_wr_en, ra_wr_data, ra_arch, ras_top, ras_empty, ras_count,
               ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, xm_instruction, xm_pc_plus_1, next_mw_d, next_mw_o,
        output ra_wr_en, ra_wr_data, ra_arch, ras_top, ras_empty, ras_count,
               ras_overflow, ras_underflow
    );

endinterface

// File: rtl/ra_stack_writer_ras_circular_stack.sv
// Circular return-address stack: push wraps over the oldest entry when full,
// pop on empty is ignored, overwrite rewrites the top in place. Flags are sticky.
module ras_circular_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   overwrite,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic [WIDTH-1:0]       fallback,
    output logic [WIDTH-1:0]       top,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [WIDTH-1:0] entry_d [DEPTH];
    logic [PW-1:0]    tp_q, tp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] top_q, top_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    always_comb begin
        // NOTE: every variable gets a hold value first so no path leaves it unassigned (no latches).
        entry_d     = entry_q;
        tp_d        = tp_q;
        cnt_d       = cnt_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (en) begin
            if (push) begin
                // NOTE: blocking assignments here so tp_d is the new pointer on the next line.
                tp_d          = tp_q + 1'b1;
                entry_d[tp_d] = wr_data;
                if (cnt_q == CW'(DEPTH)) overflow_d = 1'b1;
                else                     cnt_d      = cnt_q + 1'b1;
            end else if (overwrite) begin
                entry_d[tp_q] = wr_data;
                if (cnt_q == '0) cnt_d = CW'(1);
            end else if (pop) begin
                if (cnt_q != '0) begin
                    tp_d  = tp_q - 1'b1;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    underflow_d = 1'b1;
                end
            end
        end

        // Registered view of the post-update top; an empty stack predicts the architectural value.
        top_d = (cnt_d != '0) ? entry_d[tp_d] : fallback;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            // NOTE: the stack is a small flop array, so its entries are reset like any other state.
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
            tp_q        <= '0;
            cnt_q       <= '0;
            top_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            entry_q     <= entry_d;
            tp_q        <= tp_d;
            cnt_q       <= cnt_d;
            top_q       <= top_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign top       = top_q;
    assign count     = cnt_q;
    assign empty     = (cnt_q == '0);
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: rtl/ra_stack_writer.sv
// XM-stage link-register writer: decodes the XM instruction into the combinational
// register-file write, keeps the architectural link value and drives the return-address stack.
module ra_stack_writer
    import ra_stack_writer_pkg::*;
#(
    parameter int         WIDTH    = 32,
    parameter int         DEPTH    = 8,
    parameter logic [4:0] LINK_REG = LINK_REG_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    ra_stack_writer_if.slave   bus
);

    xm_decode_t       dec;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             upd_en;
    logic [WIDTH-1:0] ra_arch_q, ra_arch_d;

    assign dec    = decode_xm(bus.xm_instruction, LINK_REG);
    assign upd_en = !bus.stall;

    // Write port is purely combinational and ignores stall; the register file gates it itself.
    always_comb begin
        wr_en = (dec.ev == EV_PUSH) || (dec.ev == EV_OVERWRITE);
        case (dec.src)
            SRC_PC:   wr_data = bus.xm_pc_plus_1;
            SRC_LOAD: wr_data = bus.next_mw_d;
            default:  wr_data = bus.next_mw_o;
        endcase
    end

    always_comb begin
        ra_arch_d = ra_arch_q;
        if (upd_en && wr_en) ra_arch_d = wr_data;
    end

    always_ff @(posedge clock) begin
        if (!reset) ra_arch_q <= '0;
        else        ra_arch_q <= ra_arch_d;
    end

    ras_circular_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .en        (upd_en),
        .push      (dec.ev == EV_PUSH),
        .pop       (dec.ev == EV_POP),
        .overwrite (dec.ev == EV_OVERWRITE),
        .wr_data   (wr_data),
        .fallback  (ra_arch_d),
        .top       (bus.ras_top),
        .count     (bus.ras_count),
        .empty     (bus.ras_empty),
        .overflow  (bus.ras_overflow),
        .underflow (bus.ras_underflow)
    );

    assign bus.ra_wr_en   = wr_en;
    assign bus.ra_wr_data = wr_data;
    assign bus.ra_arch    = ra_arch_q;

endmodule

// File: tb/tb_ra_stack_writer.sv
// Directed bench for ra_stack_writer: a vector table for single-cycle behaviour plus
// hand-written sequences for overflow wrap, stalled repeat and reset during stall.
module tb_ra_stack_writer;
    import ra_stack_writer_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam logic [4:0] OP_NOP = 5'b00001;

    typedef struct {
        logic             rst;
        logic             stall;
        logic [4:0]       op;
        logic [4:0]       rd;
        logic [WIDTH-1:0] pc1;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] o;
        logic             exp_en;
        logic [WIDTH-1:0] exp_data;
        logic [WIDTH-1:0] exp_arch;
        logic [WIDTH-1:0] exp_top;
        int               exp_cnt;
        logic             exp_empty;
        logic             exp_ovf;
        logic             exp_unf;
    } vec_t;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;
    vec_t vq[$];

    ra_stack_writer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    ra_stack_writer #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .LINK_REG (5'd31)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] ins(input logic [4:0] op, input logic [4:0] rd);
        return {op, rd, 22'd0};
    endfunction

    function automatic vec_t v(input logic rst, input logic stall, input logic [4:0] op,
                               input logic [4:0] rd, input logic [31:0] pc1,
                               input logic [31:0] d, input logic [31:0] o,
                               input logic en, input logic [31:0] data,
                               input logic [31:0] arch, input logic [31:0] top,
                               input int cnt, input logic empty, input logic ovf,
                               input logic unf);
        vec_t r;
        r.rst = rst; r.stall = stall; r.op = op; r.rd = rd;
        r.pc1 = pc1; r.d = d; r.o = o;
        r.exp_en = en; r.exp_data = data; r.exp_arch = arch; r.exp_top = top;
        r.exp_cnt = cnt; r.exp_empty = empty; r.exp_ovf = ovf; r.exp_unf = unf;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one instruction on the falling edge; rst=1 asserts the active-low reset.
    task automatic apply(input logic rst, input logic stall, input logic [31:0] instr,
                         input logic [31:0] pc1, input logic [31:0] d, input logic [31:0] o);
        @(negedge clock);
        reset              = !rst;
        bus.stall          = stall;
        bus.xm_instruction = instr;
        bus.xm_pc_plus_1   = pc1;
        bus.next_mw_d      = d;
        bus.next_mw_o      = o;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] arch, input logic [31:0] top,
                               input int cnt, input logic empty, input logic ovf, input logic unf);
        check({tag, " ra_arch"},       64'(bus.ra_arch),       64'(arch));
        check({tag, " ras_top"},       64'(bus.ras_top),       64'(top));
        check({tag, " ras_count"},     64'(bus.ras_count),     64'(cnt));
        check({tag, " ras_empty"},     64'(bus.ras_empty),     64'(empty));
        check({tag, " ras_overflow"},  64'(bus.ras_overflow),  64'(ovf));
        check({tag, " ras_underflow"}, 64'(bus.ras_underflow), 64'(unf));
    endtask

    initial begin
        n_tests            = 0;
        n_fail             = 0;
        reset              = 1'b0;
        bus.stall          = 1'b0;
        bus.xm_instruction = '0;
        bus.xm_pc_plus_1   = '0;
        bus.next_mw_d      = '0;
        bus.next_mw_o      = '0;

        //          rst stl op       rd  pc1    d      o       en data   arch   top   cnt emp ovf unf
        vq.push_back(v(1, 0, OP_NOP,   0, 0,     0,     0,      0, 0,     0,     0,     0, 1, 0, 0));
        vq.push_back(v(0, 0, OP_JAL,   0, 'h10,  0,     0,      1, 'h10,  'h10,  'h10,  1, 0, 0, 0));
        vq.push_back(v(0, 0, OP_JAL,   0, 'h20,  0,     0,      1, 'h20,  'h20,  'h20,  2, 0, 0, 0));
        vq.push_back(v(0, 0, OP_JR,   31, 0,     0,     0,      0, 0,     'h20,  'h10,  1, 0, 0, 0));
        vq.push_back(v(0, 0, OP_JR,   31, 0,     0,     0,      0, 0,     'h20,  'h20,  0, 1, 0, 0));
        vq.push_back(v(1, 0, OP_NOP,   0, 0,     0,     'h11,   0, 'h11,  0,     0,     0, 1, 0, 0));
        vq.push_back(v(0, 0, OP_ADDI, 31, 0,     0,     'h55,   1, 'h55,  'h55,  'h55,  1, 0, 0, 0));
        vq.push_back(v(0, 0, OP_LW,   31, 0,     'hAA,  'h33,   1, 'hAA,  'hAA,  'hAA,  1, 0, 0, 0));
        vq.push_back(v(0, 0, OP_NOP,  31, 0,     0,     'h77,   0, 'h77,  'hAA,  'hAA,  1, 0, 0, 0));
        vq.push_back(v(0, 0, OP_ADDI, 30, 0,     0,     'h99,   0, 'h99,  'hAA,  'hAA,  1, 0, 0, 0));
        vq.push_back(v(0, 0, OP_JR,   30, 0,     0,     'h12,   0, 'h12,  'hAA,  'hAA,  1, 0, 0, 0));
        vq.push_back(v(0, 0, OP_RTYPE,31, 0,     'h5,   'h3C,   1, 'h3C,  'h3C,  'h3C,  1, 0, 0, 0));
        vq.push_back(v(0, 1, OP_JAL,   0, 'h40,  0,     0,      1, 'h40,  'h3C,  'h3C,  1, 0, 0, 0));
        vq.push_back(v(0, 0, OP_JAL,   0, 'h40,  0,     0,      1, 'h40,  'h40,  'h40,  2, 0, 0, 0));
        vq.push_back(v(0, 0, OP_JR,   31, 0,     0,     0,      0, 0,     'h40,  'h3C,  1, 0, 0, 0));
        vq.push_back(v(0, 0, OP_JR,   31, 0,     0,     0,      0, 0,     'h40,  'h40,  0, 1, 0, 0));
        vq.push_back(v(0, 0, OP_JR,   31, 0,     0,     0,      0, 0,     'h40,  'h40,  0, 1, 0, 1));
        vq.push_back(v(0, 0, OP_ADDI, 31, 0,     0,     'h66,   1, 'h66,  'h66,  'h66,  1, 0, 0, 1));
        vq.push_back(v(0, 0, OP_JAL,   0, 'h70,  0,     0,      1, 'h70,  'h70,  'h70,  2, 0, 0, 1));
        vq.push_back(v(1, 1, OP_JAL,   0, 'h80,  0,     0,      1, 'h80,  0,     0,     0, 1, 0, 0));

        foreach (vq[i]) begin
            apply(vq[i].rst, vq[i].stall, ins(vq[i].op, vq[i].rd), vq[i].pc1, vq[i].d, vq[i].o);
            check($sformatf("v%0d ra_wr_en", i),   64'(bus.ra_wr_en),   64'(vq[i].exp_en));
            check($sformatf("v%0d ra_wr_data", i), 64'(bus.ra_wr_data), 64'(vq[i].exp_data));
            tick();
            check_state($sformatf("v%0d", i), vq[i].exp_arch, vq[i].exp_top, vq[i].exp_cnt,
                        vq[i].exp_empty, vq[i].exp_ovf, vq[i].exp_unf);
        end

        // Nine pushes into eight entries: the oldest wraps away and overflow sticks.
        apply(1, 0, ins(OP_NOP, 0), 0, 0, 0);
        tick();
        for (int i = 1; i <= 9; i++) begin
            apply(0, 0, ins(OP_JAL, 0), 32'(i), 0, 0);
            tick();
        end
        check_state("ovf full", 9, 9, 8, 0, 1, 0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("ovf pop%0d top", k), 64'(bus.ras_top), 64'(9 - k));
            apply(0, 0, ins(OP_JR, 31), 0, 0, 0);
            tick();
        end
        check_state("ovf drained", 9, 9, 0, 1, 1, 0);

        // Pop on empty, then a jal held for three stalled cycles pushes exactly once.
        apply(1, 0, ins(OP_NOP, 0), 0, 0, 0);
        tick();
        apply(0, 0, ins(OP_JR, 31), 0, 0, 0);
        tick();
        check_state("unf", 0, 0, 0, 1, 0, 1);
        for (int c = 0; c < 3; c++) begin
            apply(0, 1, ins(OP_JAL, 0), 'h5, 0, 0);
            check($sformatf("stall%0d ra_wr_en", c), 64'(bus.ra_wr_en), 64'(1));
            tick();
            check($sformatf("stall%0d ras_count", c), 64'(bus.ras_count), 64'(0));
        end
        apply(0, 0, ins(OP_JAL, 0), 'h5, 0, 0);
        tick();
        apply(0, 0, ins(OP_NOP, 0), 0, 0, 0);
        tick();
        check_state("stall release", 'h5, 'h5, 1, 0, 0, 1);

        // Two more pushes (three total), then reset asserted while stalled wins.
        apply(0, 0, ins(OP_JAL, 0), 'h6, 0, 0);
        tick();
        apply(0, 0, ins(OP_JAL, 0), 'h7, 0, 0);
        tick();
        check_state("three pushes", 'h7, 'h7, 3, 0, 0, 1);
        apply(1, 1, ins(OP_JAL, 0), 'h8, 0, 0);
        tick();
        check_state("reset in stall", 0, 0, 0, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ra_stack_writer.md
Name: ra_stack_writer

Overview:
Parametrised successor to the link-register writer in the XM stage. It decodes the XM instruction and produces the register-file write for the link register (LINK_REG, default r31). It also keeps a registered architectural copy of that register and a circular return-address stack (RAS) of DEPTH entries. Fetch reads the RAS top as the predicted target for jr through the link register.

Parameters:
WIDTH, 32, datapath and PC width
DEPTH, 8, RAS entries; power of two, minimum 2
LINK_REG, 5'd31, register index treated as the link register

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low; 0 at a rising edge resets all state
stall  in  1  XM held this cycle; no state update
xm_instruction  in  32  XM-latch instruction; opcode [31:27], rd [26:22]
xm_pc_plus_1  in  WIDTH  XM-latch PC+1
next_mw_d  in  WIDTH  load data heading to MW
next_mw_o  in  WIDTH  ALU result heading to MW
ra_wr_en  out  1  combinational write enable for LINK_REG
ra_wr_data  out  WIDTH  combinational write data for LINK_REG
ra_arch  out  WIDTH  registered architectural link-register value
ras_top  out  WIDTH  registered predicted return target
ras_empty  out  1  RAS count == 0
ras_count  out  $clog2(DEPTH)+1  live RAS entries
ras_overflow  out  1  sticky: a push was made while full
ras_underflow  out  1  sticky: a pop was made while empty

Behaviour:
- Opcodes: R-type 00000, addi 00101, lw 01000, jal 00011, jr 00100. Everything else is a no-op for this block.
- Event decode, mutually exclusive (one instruction per cycle):
  - PUSH: jal.
  - OVERWRITE: R-type, addi or lw with rd == LINK_REG.
  - POP: jr with rd == LINK_REG.
- Write port, combinational, active even during stall:
  - ra_wr_en = PUSH | OVERWRITE.
  - ra_wr_data = xm_pc_plus_1 for jal; next_mw_d for lw; otherwise next_mw_o.
- State update at a rising edge only when reset == 1 and stall == 0. reset == 0 has priority over stall.
- ra_arch:
  - Loads ra_wr_data when ra_wr_en.
  - Holds on POP, because jr does not modify the register.
- RAS storage: array of DEPTH entries, top pointer tp (log2 DEPTH bits, wraps modulo DEPTH), count cnt.
- PUSH:
  - tp <= tp+1; write entry[tp+1] = xm_pc_plus_1.
  - cnt <= min(cnt+1, DEPTH).
  - If cnt == DEPTH before the push, the oldest entry is overwritten (wrap) and ras_overflow is set.
- OVERWRITE:
  - entry[tp] <= ra_wr_data; pointer unchanged.
  - If cnt == 0, cnt becomes 1.
- POP:
  - If cnt > 0: tp <= tp-1, cnt <= cnt-1.
  - If cnt == 0: no change to tp or cnt; ras_underflow is set.
- ras_top = entry[tp] when cnt > 0, else ra_arch (fallback). Registered, visible the cycle after the event.
- Reset values: ra_arch 0, tp 0, cnt 0, all entries 0, ras_top 0, ras_empty 1, sticky flags 0.
- Outputs ra_wr_en and ra_wr_data have no reset value; they are pure functions of their inputs.
- Latency:
  - Write port: 0 cycles.
  - ra_arch and RAS outputs: 1 cycle after the enabling edge.
- Stalled repeat: a stalled instruction causes exactly one update, on its first unstalled edge.
- Reset mid-sequence discards all stack contents.

Decomposition:
- Shared package: opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_JAL, OP_JR) and LINK_REG_DEFAULT, reused by the decode logic elsewhere.
- One natural sub-module, ras_circular_stack(WIDTH, DEPTH): push/pop/overwrite ports, top output, count and sticky flags. The top level holds the decode and ra_arch.

Test Plan:
- Reset then jal with pc_plus_1 = 0x10 -> same cycle ra_wr_en = 1, ra_wr_data = 0x10; next cycle ra_arch = 0x10, ras_top = 0x10, ras_count = 1.
- jal 0x10, jal 0x20, jr r31, jr r31 -> ras_top sequence 0x10, 0x20, 0x10, then fallback ra_arch = 0x20; ras_empty = 1; ras_underflow = 0.
- addi r31 with next_mw_o = 0x55, then lw r31 with next_mw_d = 0xAA, no-op case with next_mw_o = 0x77 -> ra_wr_data 0x55 then 0xAA; ras_top 0x55 then 0xAA; ras_count stays 1; addi r30 -> ra_wr_en = 0.
- DEPTH = 8: nine jals with pc_plus_1 = 1..9 -> ras_count = 8, ras_overflow = 1; eight pops return 9..2.
- jr r31 while empty -> ras_underflow = 1, ras_count = 0; jal held with stall = 1 for 3 cycles -> exactly one push.
- Drive reset = 0 while stall = 1 after 3 pushes -> all outputs at reset values next cycle.
